// File: rtl/spi_mem_slave.sv
// Serial memory slave sampled on the system clock: command bit, LSB-first address,
// then burst write or burst read with wrap at DEPTH and out-of-range error pulses.
module spi_mem_slave #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic mosi,
  output logic miso,
  output logic ready,
  output logic op_done,
  output logic err
);

  localparam int unsigned MAX_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int unsigned CNT_W = $clog2(MAX_W + 1);
  localparam int unsigned CMP_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    RLOAD = 3'd3,
    RDATA = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic              is_wr, is_wr_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [ADDR_W-1:0] addr, addr_nx, addr_inc, addr_in;
  logic [DATA_W-1:0] sreg, sreg_nx, sreg_in;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              miso_nx, ready_nx, op_done_nx, err_nx, mem_we;
  logic              addr_oor, cnt_addr_last, cnt_data_last, cnt_full;

  // Comparisons are one bit wider so DEPTH == 2**ADDR_W stays representable.
  assign addr_oor      = CMP_W'(addr) >= CMP_W'(DEPTH);
  assign addr_inc      = (CMP_W'(addr) >= CMP_W'(DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
  assign addr_in       = (addr >> 1) | (ADDR_W'(mosi) << (ADDR_W - 1));
  assign sreg_in       = (sreg >> 1) | (DATA_W'(mosi) << (DATA_W - 1));
  assign cnt_addr_last = cnt == CNT_W'(ADDR_W - 1);
  assign cnt_data_last = cnt == CNT_W'(DATA_W - 1);
  assign cnt_full      = cnt == CNT_W'(DATA_W);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic; a read word boundary returns to RLOAD even if cs dropped.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (cs) state_nx = ADDR;
      ADDR: begin
        if (!cs)                state_nx = IDLE;
        else if (cnt_addr_last) state_nx = is_wr ? WDATA : RLOAD;
      end
      WDATA: if (!cs) state_nx = IDLE;
      RLOAD: state_nx = cs ? RDATA : IDLE;
      RDATA: begin
        if (cnt_full) state_nx = RLOAD;
        else if (!cs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output and datapath next values; every abort path falls through to the defaults.
  always_comb begin
    is_wr_nx   = is_wr;
    cnt_nx     = cnt;
    addr_nx    = addr;
    sreg_nx    = sreg;
    miso_nx    = 1'b0;
    ready_nx   = 1'b0;
    op_done_nx = 1'b0;
    err_nx     = 1'b0;
    mem_we     = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs) begin
          is_wr_nx = mosi;
          cnt_nx   = '0;
        end
      end
      ADDR: begin
        if (cs) begin
          addr_nx = addr_in;
          cnt_nx  = cnt_addr_last ? '0 : cnt + CNT_W'(1);
        end
      end
      WDATA: begin
        if (cs) begin
          sreg_nx = sreg_in;
          if (cnt_data_last) begin
            mem_we     = !addr_oor;
            op_done_nx = 1'b1;
            err_nx     = addr_oor;
            addr_nx    = addr_inc;
            cnt_nx     = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end
      RLOAD: begin
        if (cs) begin
          sreg_nx  = addr_oor ? '0 : mem[addr];
          ready_nx = 1'b1;
          err_nx   = addr_oor;
          cnt_nx   = '0;
        end
      end
      RDATA: begin
        if (cnt_full) begin
          op_done_nx = 1'b1;
          addr_nx    = addr_inc;
        end else if (cs) begin
          miso_nx = sreg[0];
          sreg_nx = sreg >> 1;
          cnt_nx  = cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath, memory and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_wr   <= 1'b0;
      cnt     <= '0;
      addr    <= '0;
      sreg    <= '0;
      miso    <= 1'b0;
      ready   <= 1'b0;
      op_done <= 1'b0;
      err     <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      is_wr   <= is_wr_nx;
      cnt     <= cnt_nx;
      addr    <= addr_nx;
      sreg    <= sreg_nx;
      miso    <= miso_nx;
      ready   <= ready_nx;
      op_done <= op_done_nx;
      err     <= err_nx;
      if (mem_we) mem[addr] <= sreg_in;
    end
  end

endmodule

// File: tb/tb_spi_mem_slave.sv
// Scoreboard bench for spi_mem_slave: a DEPTH=32 and a DEPTH=20 instance with a shared reset.
module tb_spi_mem_slave;

  typedef struct {
    logic       rd;
    logic [7:0] data;
    logic       err;
    int         rdy_edge;
    int         done_edge;
  } exp_t;

  logic clk, rst;
  logic cs_a, mosi_a, miso_a, ready_a, op_done_a, err_a;
  logic cs_b, mosi_b, miso_b, ready_b, op_done_b, err_b;
  logic miso_s, ready_s, op_done_s, err_s;
  bit   sel;
  int   fedge;
  int   n_checks, n_errors;
  exp_t exp_q[$];
  logic [7:0] mdl [2][32];

  spi_mem_slave u_dut_a (
    .clk(clk), .rst(rst), .cs(cs_a), .mosi(mosi_a),
    .miso(miso_a), .ready(ready_a), .op_done(op_done_a), .err(err_a)
  );

  spi_mem_slave #(.DEPTH(20)) u_dut_b (
    .clk(clk), .rst(rst), .cs(cs_b), .mosi(mosi_b),
    .miso(miso_b), .ready(ready_b), .op_done(op_done_b), .err(err_b)
  );

  assign miso_s    = sel ? miso_b    : miso_a;
  assign ready_s   = sel ? ready_b   : ready_a;
  assign op_done_s = sel ? op_done_b : op_done_a;
  assign err_s     = sel ? err_b     : err_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int next_addr(input int a, input int dep);
    return (a >= dep - 1) ? 0 : a + 1;
  endfunction

  // One frame edge: inputs set after the previous edge, sampled at the next one.
  task automatic drive(input logic c, input logic m);
    if (sel) begin cs_b = c; mosi_b = m; end
    else     begin cs_a = c; mosi_a = m; end
    @(posedge clk);
    fedge++;
    #1;
  endtask

  task automatic send_hdr(input logic cmd, input int a);
    logic [4:0] av;
    av = 5'(a);
    fedge = -1;
    drive(1'b1, cmd);
    for (int i = 0; i < 5; i++) drive(1'b1, av[i]);
  endtask

  task automatic write_frame(input bit s, input int a, input logic [23:0] words, input int nbits);
    int ad, dep;
    logic [7:0] wd;
    logic oor;
    sel = s; dep = s ? 20 : 32; ad = a;
    send_hdr(1'b1, a);
    for (int b = 0; b < nbits; b++) begin
      wd = 8'(words >> (8 * (b / 8)));
      if (b % 8 == 7) begin
        oor = (ad >= dep);
        exp_q.push_back('{rd: 1'b0, data: wd, err: oor, rdy_edge: 0, done_edge: 5 + (b / 8 + 1) * 8});
        if (!oor) mdl[s][ad] = wd;
        ad = next_addr(ad, dep);
      end
      drive(1'b1, wd[b % 8]);
    end
    drive(1'b0, 1'b0);
  endtask

  task automatic read_frame(input bit s, input int a, input int n);
    int ad, dep;
    logic oor;
    sel = s; dep = s ? 20 : 32; ad = a;
    for (int k = 0; k < n; k++) begin
      oor = (ad >= dep);
      exp_q.push_back('{rd: 1'b1, data: oor ? 8'h00 : mdl[s][ad], err: oor,
                        rdy_edge: 6 + 10 * k, done_edge: 15 + 10 * k});
      ad = next_addr(ad, dep);
    end
    send_hdr(1'b0, a);
    for (int e = 0; e < 10 * n; e++) drive(1'b1, 1'($urandom));
    drive(1'b0, 1'b0);
  endtask

  // Monitor: pulse widths, idle miso, ready/op_done timing and read data against the queue.
  int         bitcnt;
  bit         collecting, in_bits;
  logic [7:0] word;
  logic       prev_rdy, prev_done, prev_err;
  exp_t       e;

  always @(negedge clk) begin
    if (!rst) begin
      collecting = 1'b0; bitcnt = 0;
      prev_rdy = 1'b0; prev_done = 1'b0; prev_err = 1'b0;
    end else begin
      in_bits = collecting && bitcnt < 8;
      if (ready_s)   check("ready_pulse", 32'(prev_rdy), 0);
      if (op_done_s) check("done_pulse", 32'(prev_done), 0);
      if (err_s)     check("err_pulse", 32'(prev_err), 0);
      if (err_s && !ready_s && !op_done_s) check("err_alone", 32'(err_s), 0);
      if (!in_bits && miso_s) check("miso_idle", 32'(miso_s), 0);
      if (ready_s) begin
        if (exp_q.size() == 0 || !exp_q[0].rd) check("unexp_ready", 32'(ready_s), 0);
        else begin
          check("ready_edge", fedge, exp_q[0].rdy_edge);
          check("ready_err", 32'(err_s), 32'(exp_q[0].err));
          collecting = 1'b1; bitcnt = 0; word = 8'h00;
        end
      end else if (in_bits) begin
        word[bitcnt] = miso_s;
        bitcnt++;
      end
      if (op_done_s) begin
        if (exp_q.size() == 0) check("unexp_done", 32'(op_done_s), 0);
        else begin
          e = exp_q.pop_front();
          check("done_edge", fedge, e.done_edge);
          if (e.rd) begin
            check("rd_data", 32'(word), 32'(e.data));
            check("rd_bits", bitcnt, 8);
            check("rd_done_err", 32'(err_s), 0);
            collecting = 1'b0;
          end else begin
            check("wr_err", 32'(err_s), 32'(e.err));
          end
        end
      end
      prev_rdy = ready_s; prev_done = op_done_s; prev_err = err_s;
    end
  end

  task automatic check_outputs_low(input string tag);
    check({tag, "_miso_a"}, 32'(miso_a), 0);
    check({tag, "_ready_a"}, 32'(ready_a), 0);
    check({tag, "_done_a"}, 32'(op_done_a), 0);
    check({tag, "_err_a"}, 32'(err_a), 0);
    check({tag, "_miso_b"}, 32'(miso_b), 0);
    check({tag, "_ready_b"}, 32'(ready_b), 0);
    check({tag, "_done_b"}, 32'(op_done_b), 0);
    check({tag, "_err_b"}, 32'(err_b), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_errors = 0; sel = 1'b0; fedge = 0;
    rst = 1'b0; cs_a = 1'b0; mosi_a = 1'b0; cs_b = 1'b0; mosi_b = 1'b0;
    for (int s = 0; s < 2; s++) for (int i = 0; i < 32; i++) mdl[s][i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_outputs_low("reset");

    write_frame(1'b0, 3, 24'hA5, 8);
    read_frame(1'b0, 3, 1);

    write_frame(1'b0, 31, 24'h2211, 16);
    read_frame(1'b0, 31, 3);

    write_frame(1'b0, 7, 24'hFF, 4);
    read_frame(1'b0, 7, 1);

    write_frame(1'b1, 25, 24'hFF, 8);
    read_frame(1'b1, 25, 1);
    write_frame(1'b1, 19, 24'hC35A, 16);
    read_frame(1'b1, 19, 2);
    read_frame(1'b1, 5, 1);

    // Async reset in the middle of a read, right after bit 3 appears on miso.
    sel = 1'b0;
    exp_q.push_back('{rd: 1'b1, data: mdl[0][3], err: 1'b0, rdy_edge: 6, done_edge: 15});
    send_hdr(1'b0, 3);
    repeat (5) drive(1'b1, 1'b0);
    #2 rst = 1'b0;
    #1 check_outputs_low("async_rst");
    exp_q.delete();
    for (int s = 0; s < 2; s++) for (int i = 0; i < 32; i++) mdl[s][i] = 8'h00;
    cs_a = 1'b0; mosi_a = 1'b0;
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    read_frame(1'b0, 3, 1);
    read_frame(1'b1, 19, 1);

    for (int it = 0; it < 5; it++) begin
      int a, n;
      logic [23:0] w;
      a = $urandom_range(0, 31);
      n = $urandom_range(1, 3);
      w = 24'($urandom);
      write_frame(1'b0, a, w, 8 * n);
      read_frame(1'b0, a, n);
    end

    repeat (3) @(posedge clk);
    #1 check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
